// File: rtl/iob_sp_ram_be.sv
// rtl/iob_sp_ram_be.sv - single-port synchronous RAM with byte strobes and rvalid
//
// Purpose: 2**ADDR_W x DATA_W single-port RAM. Byte-strobed writes, fixed read
// latency of 1 + OUT_REG cycles qualified by rvalid, optional write-first return
// of the merged word, and an optional post-reset clear sweep.
//
// Optional feature macro: IOB_SP_RAM_CLEAR_EN (zero-fill sweep after rst, busy high).
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous active-high reset
//   en     in   1          access request, ignored while busy
//   we     in   DATA_W/8   byte write strobes, all-zero = read
//   addr   in   ADDR_W     word address
//   din    in   DATA_W     write data, byte i = din[8i+7:8i]
//   dout   out  DATA_W     read data, holds between rvalid pulses
//   rvalid out  1          one pulse per returned word
//   busy   out  1          clear sweep in progress (0 without the macro)

module iob_sp_ram_be #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int OUT_REG     = 0,
   parameter int WRITE_FIRST = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout,
   output logic                rvalid,
   output logic                busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc;
   logic              is_wr;
   logic              ret;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_waddr;
   logic [NB-1:0]     mem_wbe;
   logic [DATA_W-1:0] mem_wdata;

`ifdef IOB_SP_RAM_CLEAR_EN
   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (&cnt_q) begin
            state_d = READY;
         end
      end
      busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
`else
   assign busy = 1'b0;
`endif

   // Single write port shared by user writes and the clear sweep; the sweep
   // never collides with a user write because busy blocks acceptance.
   always_comb begin
      acc       = en && !busy;
      is_wr     = |we;
      ret       = acc && (!is_wr || (WRITE_FIRST != 0));
      mem_wen   = acc && is_wr;
      mem_waddr = addr;
      mem_wbe   = we;
      mem_wdata = din;
`ifdef IOB_SP_RAM_CLEAR_EN
      if (state_q == CLEAR && !rst) begin
         mem_wen   = 1'b1;
         mem_waddr = cnt_q;
         mem_wbe   = '1;
         mem_wdata = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_wen) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_wbe[i]) begin
               mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // Stage 1 captures the pre-write word plus the write bytes; merging after
   // the register yields the post-write word for write-first returns without
   // needing a read-after-write path through the array. For reads we is zero,
   // so the merge passes the stored word straight through.
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] rd_word_q, rd_word_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [NB-1:0]     wr_be_q, wr_be_d;
   logic [DATA_W-1:0] s1_word;

   always_comb begin
      s1_valid_d = ret;
      rd_word_d  = rd_word_q;
      wr_data_d  = wr_data_q;
      wr_be_d    = wr_be_q;
      // Only returned accesses load stage 1, so dout holds between pulses.
      if (ret) begin
         rd_word_d = mem[addr];
         wr_data_d = din;
         wr_be_d   = we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         rd_word_q  <= '0;
         wr_data_q  <= '0;
         wr_be_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         rd_word_q  <= rd_word_d;
         wr_data_q  <= wr_data_d;
         wr_be_q    <= wr_be_d;
      end
   end

   always_comb begin
      s1_word = rd_word_q;
      for (int i = 0; i < NB; i++) begin
         if (wr_be_q[i]) begin
            s1_word[8*i +: 8] = wr_data_q[8*i +: 8];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] dout_q, dout_d;
         logic              rvalid_q, rvalid_d;

         always_comb begin
            rvalid_d = s1_valid_q;
            dout_d   = dout_q;
            if (s1_valid_q) begin
               dout_d = s1_word;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q   <= '0;
               rvalid_q <= 1'b0;
            end else begin
               dout_q   <= dout_d;
               rvalid_q <= rvalid_d;
            end
         end

         assign dout   = dout_q;
         assign rvalid = rvalid_q;
      end else begin : g_no_out_reg
         assign dout   = s1_word;
         assign rvalid = s1_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_iob_sp_ram_be.sv
// tb/tb_iob_sp_ram_be.sv - self-checking bench for iob_sp_ram_be
//
// Two instances share one stimulus stream: dut0 (OUT_REG=0, WRITE_FIRST=0) and
// dut1 (OUT_REG=1, WRITE_FIRST=1). Follows IOB_SP_RAM_CLEAR_EN like the RTL.

module tb_iob_sp_ram_be;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  we;
   logic [3:0]  addr;
   logic [31:0] din;
   logic [31:0] dout0, dout1;
   logic        rv0, rv1;
   logic        busy0, busy1;

   int checks   = 0;
   int failures = 0;

   // Reference state: memory image, last returned word per instance, and the
   // word dut1 owes one sample later because of its extra output stage.
   logic [31:0] model [16];
   logic [31:0] last0, last1;
   logic        p1_v;
   logic [31:0] p1_d;

   always #5 clk = ~clk;

   iob_sp_ram_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .WRITE_FIRST(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
      .dout(dout0), .rvalid(rv0), .busy(busy0)
   );

   iob_sp_ram_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .WRITE_FIRST(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
      .dout(dout1), .rvalid(rv1), .busy(busy1)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   // One clock of traffic: drive, let the edge pass, compare both instances.
   task automatic do_cycle(input logic e, input logic [3:0] w, input logic [3:0] a,
                           input logic [31:0] d, input string tag);
      logic        wr;
      logic        r0v, r1v;
      logic [31:0] r0d, r1d, nw, exp0, exp1;
      en   = e;
      we   = w;
      addr = a;
      din  = d;
      wr   = (w != 4'd0);
      nw   = merge(model[a], d, w);
      r0v  = e && !wr;
      r0d  = model[a];
      r1v  = e;
      r1d  = wr ? nw : model[a];
      if (e && wr) model[a] = nw;
      @(posedge clk);
      @(negedge clk);
      exp0 = r0v ? r0d : last0;
      exp1 = p1_v ? p1_d : last1;
      checks++;
      if (rv0 !== r0v) begin
         failures++;
         $display("FAIL %s dut0 rvalid: got %0b want %0b", tag, rv0, r0v);
      end
      checks++;
      if (dout0 !== exp0) begin
         failures++;
         $display("FAIL %s dut0 dout: got %08h want %08h", tag, dout0, exp0);
      end
      checks++;
      if (rv1 !== p1_v) begin
         failures++;
         $display("FAIL %s dut1 rvalid: got %0b want %0b", tag, rv1, p1_v);
      end
      checks++;
      if (dout1 !== exp1) begin
         failures++;
         $display("FAIL %s dut1 dout: got %08h want %08h", tag, dout1, exp1);
      end
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL %s busy: got %0b/%0b want 0/0", tag, busy0, busy1);
      end
      last0 = exp0;
      last1 = exp1;
      p1_v  = r1v;
      p1_d  = r1d;
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 4'd0, 4'd0, 32'd0, "idle");
   endtask

   // Called on the negedge right after the last reset edge with rst just dropped.
   task automatic check_after_reset(input string tag);
`ifdef IOB_SP_RAM_CLEAR_EN
      logic exp_b;
      for (int i = 0; i < 20; i++) begin
         exp_b = (i < 16);
         checks++;
         if (busy0 !== exp_b || busy1 !== exp_b) begin
            failures++;
            $display("FAIL %s busy[%0d]: got %0b/%0b want %0b", tag, i, busy0, busy1, exp_b);
         end
         checks++;
         if (rv0 !== 1'b0 || rv1 !== 1'b0 || dout0 !== 32'd0 || dout1 !== 32'd0) begin
            failures++;
            $display("FAIL %s sweep out[%0d]: got rv=%0b/%0b dout=%08h/%08h want 0", tag, i,
                     rv0, rv1, dout0, dout1);
         end
         // Late in the sweep address 2 is already cleared, so an accepted write would stick.
         en   = (i == 10);
         we   = 4'hF;
         addr = 4'd2;
         din  = 32'hDEADBEEF;
         @(posedge clk);
         @(negedge clk);
         en = 1'b0;
      end
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
`else
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL %s busy: got %0b/%0b want 0/0", tag, busy0, busy1);
      end
`endif
      last0 = 32'd0;
      last1 = 32'd0;
      p1_v  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      we  = 4'd0;
      addr = 4'd0;
      din = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
         failures++;
         $display("FAIL reset rvalid: got %0b/%0b want 0/0", rv0, rv1);
      end
      checks++;
      if (dout0 !== 32'd0 || dout1 !== 32'd0) begin
         failures++;
         $display("FAIL reset dout: got %08h/%08h want 0/0", dout0, dout1);
      end
      rst = 1'b0;
      check_after_reset("reset");
   endtask

   task automatic test_zero_readback();
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'd0, 4'(i), 32'd0, "zero_rd");
      flush(2);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'hF, 4'(i), $urandom, "fill");
      flush(2);
   endtask

   task automatic test_byte_strobe();
      do_cycle(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, "strobe");
      do_cycle(1'b1, 4'h5, 4'd5, 32'h11223344, "strobe");
      do_cycle(1'b1, 4'h0, 4'd5, 32'd0, "strobe");
      checks++;
      if (rv0 !== 1'b1 || dout0 !== 32'hAA22CC44) begin
         failures++;
         $display("FAIL strobe dut0: got rv=%0b %08h want rv=1 aa22cc44", rv0, dout0);
      end
      do_cycle(1'b0, 4'h0, 4'd0, 32'd0, "strobe");
      checks++;
      if (rv1 !== 1'b1 || dout1 !== 32'hAA22CC44) begin
         failures++;
         $display("FAIL strobe dut1: got rv=%0b %08h want rv=1 aa22cc44", rv1, dout1);
      end
      flush(1);
   endtask

   task automatic test_streaming();
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b1, 4'd0, 4'(i), 32'd0, "stream");
         if (rv1 === 1'b1) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b0, 4'd0, 4'd0, 32'd0, "stream");
         if (rv1 === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 8) begin
         failures++;
         $display("FAIL stream pulses: got %0d want 8", pulses);
      end
   endtask

   task automatic test_write_first();
      do_cycle(1'b1, 4'hF, 4'd3, 32'h00000000, "wfirst");
      do_cycle(1'b1, 4'h8, 4'd3, 32'hFFFFFFFF, "wfirst");
      checks++;
      if (rv0 !== 1'b0) begin
         failures++;
         $display("FAIL wfirst dut0 rvalid: got %0b want 0", rv0);
      end
      do_cycle(1'b0, 4'h0, 4'd0, 32'd0, "wfirst");
      checks++;
      if (rv1 !== 1'b1 || dout1 !== 32'hFF000000) begin
         failures++;
         $display("FAIL wfirst dut1: got rv=%0b %08h want rv=1 ff000000", rv1, dout1);
      end
      flush(1);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  a;
      logic [31:0] d;
      for (int k = 0; k < 4; k++) begin
         a = 4'($urandom_range(0, 15));
         d = $urandom;
         do_cycle(1'b1, 4'hF, a, d, "b2b");
         do_cycle(1'b1, 4'h0, a, 32'd0, "b2b");
         checks++;
         if (dout0 !== d) begin
            failures++;
            $display("FAIL b2b readback: got %08h want %08h", dout0, d);
         end
      end
      flush(2);
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         do_cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom),
                  4'($urandom), $urandom, "random");
      end
      flush(2);
   endtask

   task automatic test_reset_mid();
      do_cycle(1'b1, 4'd0, 4'd9, 32'd0, "rst_mid");
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid rvalid: got %0b/%0b want 0/0", rv0, rv1);
      end
      checks++;
      if (dout0 !== 32'd0 || dout1 !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid dout: got %08h/%08h want 0/0", dout0, dout1);
      end
      rst = 1'b0;
      check_after_reset("rst_mid");
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'd0, 4'(i), 32'd0, "post_rst");
      flush(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      last0 = 32'd0;
      last1 = 32'd0;
      p1_v  = 1'b0;
      p1_d  = 32'd0;
      test_reset();
`ifdef IOB_SP_RAM_CLEAR_EN
      test_zero_readback();
`endif
      test_fill();
      test_byte_strobe();
      test_streaming();
      test_write_first();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
